counter_reader: RTL and testbench

//  Requester/consumer side of the FIFO pop-counter readout interface. On start, while the

---
 rtl/counter_reader_if.sv | 17 +
 rtl/counter_reader.sv | 164 ++++++++++++++++
 tb/tb_counter_reader.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_reader_if.sv
// Counter readout bus between the requester (counter_reader) and the pop counter block.
// Latency: none, this is wiring only; the requester's outputs are registered on its side.
// Backpressure: the requester holds req/idx steady until the counter block returns cnt_valid.
interface counter_reader_if #(
  parameter int CNT_W = 5,
  parameter int IDX_W = 3
) ();
  logic             req;
  logic [IDX_W-1:0] idx;
  logic             cnt_valid;
  logic [CNT_W-1:0] cnt_data;

  // Requester side: drives req/idx and receives the count
  modport master (output req, output idx, input cnt_valid, input cnt_data);
  // Counter block side: receives req/idx and returns the count
  modport slave  (input req, input idx, output cnt_valid, output cnt_data);
endinterface

// File: rtl/counter_reader.sv
// Sweeps idx 0..NUM_FIFOS-1 while the system is IDLE and captures each returned pop count plus the running total.
// Latency: one capture per cnt_valid cycle; done pulses on the cycle after the last capture; all outputs registered.
// Backpressure: req/idx are held until cnt_valid; an optional response timeout is enabled by COUNTER_READER_TIMEOUT_EN.
module counter_reader #(
  parameter int NUM_FIFOS   = 5,
  parameter int CNT_W       = 5,
  parameter int IDX_W       = 3,
  parameter int SUM_W       = 8,
  parameter int TIMEOUT_CYC = 8
) (
  input  logic                    clk,
  input  logic                    reset_L,
  input  logic                    start,
  input  logic                    IDLE,
  counter_reader_if.master        bus,
  output logic [CNT_W-1:0]        cnt0,
  output logic [CNT_W-1:0]        cnt1,
  output logic [CNT_W-1:0]        cnt2,
  output logic [CNT_W-1:0]        cnt3,
  output logic [CNT_W-1:0]        cnt4,
  output logic [SUM_W-1:0]        total,
  output logic                    busy,
  output logic                    done,
  output logic                    abort,
  output logic                    timeout_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // The port list exposes five count registers; the sweep length is NUM_FIFOS.
  localparam int               NUM_REGS = 5;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIFOS - 1);

  logic [1:0]       state_q;
  logic             req_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [SUM_W-1:0] total_q;
  logic             busy_q;
  logic             done_q;
  logic             abort_q;
  logic             timeout_err_q;
  logic             timeout_hit;

`ifdef COUNTER_READER_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

  logic [WAIT_W-1:0] wait_q;

  // Fires on the TIMEOUT_CYC-th consecutive S_REQ cycle with no response; IDLE falling wins over it.
  assign timeout_hit = (state_q == S_REQ) && IDLE && !bus.cnt_valid &&
                       (wait_q == WAIT_W'(TIMEOUT_CYC - 1));

  // Wait counter: restarts on every capture (which is also every idx change) and outside S_REQ
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wait_q <= '0;
    end else if ((state_q != S_REQ) || bus.cnt_valid || timeout_hit) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_q + WAIT_W'(1);
    end
  end
`else
  // Without the timeout feature S_REQ waits indefinitely; this comparison is constant false
  // and only keeps the shared parameter list referenced in this build.
  assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

  // Sweep FSM: start/abort/capture/done sequencing and all registered outputs
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q       <= S_IDLE;
      req_q         <= 1'b0;
      idx_q         <= '0;
      total_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      abort_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      // done and abort are single-cycle pulses unless re-asserted below
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // start without IDLE is dropped, not remembered
          if (start && IDLE) begin
            state_q       <= S_REQ;
            req_q         <= 1'b1;
            busy_q        <= 1'b1;
            idx_q         <= '0;
            total_q       <= '0;
            timeout_err_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
              cnt_q[i] <= '0;
            end
          end
        end
        S_REQ: begin
          if (!IDLE) begin
            // System left idle: stop reading, keep what was already captured
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            idx_q   <= '0;
            abort_q <= 1'b1;
          end else if (bus.cnt_valid) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (idx_q == IDX_W'(i)) begin
                cnt_q[i] <= bus.cnt_data;
              end
            end
            total_q <= total_q + SUM_W'(bus.cnt_data);
            if (idx_q == LAST_IDX) begin
              state_q <= S_DONE;
              req_q   <= 1'b0;
              busy_q  <= 1'b0;
              idx_q   <= '0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else if (timeout_hit) begin
            state_q       <= S_IDLE;
            req_q         <= 1'b0;
            busy_q        <= 1'b0;
            idx_q         <= '0;
            timeout_err_q <= 1'b1;
          end
        end
        S_DONE: begin
          // done was raised on entry; it drops as we return to idle
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign bus.req     = req_q;
  assign bus.idx     = idx_q;
  assign cnt0        = cnt_q[0];
  assign cnt1        = cnt_q[1];
  assign cnt2        = cnt_q[2];
  assign cnt3        = cnt_q[3];
  assign cnt4        = cnt_q[4];
  assign total       = total_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign abort       = abort_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_counter_reader.sv
// Directed plus randomized bench for counter_reader; the counter block is modelled by the sequence below.
// Latency: inputs driven and outputs sampled on the falling edge, half a cycle away from the active edge.
// Backpressure: response latency per FIFO is chosen per sweep; COUNTER_READER_TIMEOUT_EN selects the timeout checks.
module tb_counter_reader;

  logic       clk;
  logic       reset_L;
  logic       start;
  logic       IDLE;
  logic [4:0] cnt0, cnt1, cnt2, cnt3, cnt4;
  logic [7:0] total;
  logic       busy, done, abort, timeout_err;

  counter_reader_if #(.CNT_W(5), .IDX_W(3)) bus ();

  counter_reader dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .start       (start),
    .IDLE        (IDLE),
    .bus         (bus),
    .cnt0        (cnt0),
    .cnt1        (cnt1),
    .cnt2        (cnt2),
    .cnt3        (cnt3),
    .cnt4        (cnt4),
    .total       (total),
    .busy        (busy),
    .done        (done),
    .abort       (abort),
    .timeout_err (timeout_err)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference state: what each count register and the total should hold
  int exp_cnt [5];
  int exp_total;
  // Per-sweep stimulus: response latency (idle cycles) and returned data per FIFO
  int         lat_a [5];
  logic [4:0] dat_a [5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] get_cnt(input int i);
    case (i)
      0: return cnt0;
      1: return cnt1;
      2: return cnt2;
      3: return cnt3;
      default: return cnt4;
    endcase
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 5; k++) exp_cnt[k] = 0;
    exp_total = 0;
  endtask

  task automatic chk_outs(input string tag);
    for (int k = 0; k < 5; k++) chk($sformatf("%s_cnt%0d", tag, k), 32'(get_cnt(k)), exp_cnt[k]);
    chk($sformatf("%s_total", tag), 32'(total), exp_total);
  endtask

  // One sweep; abort_at in 0..4 drops IDLE when that idx is requested (with a competing cnt_valid)
  task automatic sweep(input string tag, input int abort_at);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    model_clear();
    chk({tag, "_start_req"}, 32'(bus.req), 1);
    chk({tag, "_start_busy"}, 32'(busy), 1);
    chk({tag, "_start_terr"}, 32'(timeout_err), 0);
    chk_outs({tag, "_cleared"});
    for (int i = 0; i < 5; i++) begin
      for (int w = 0; w < lat_a[i]; w++) begin
        start = 1'($urandom_range(0, 1));  // start while busy must be ignored
        @(negedge clk);
      end
      start = 1'b0;
      chk($sformatf("%s_req%0d", tag, i), 32'(bus.req), 1);
      chk($sformatf("%s_idx%0d", tag, i), 32'(bus.idx), i);
      if (i == abort_at) begin
        IDLE = 1'b0; bus.cnt_valid = 1'b1; bus.cnt_data = dat_a[i];
        @(negedge clk);
        IDLE = 1'b1; bus.cnt_valid = 1'b0;
        chk({tag, "_abort"}, 32'(abort), 1);
        chk({tag, "_abort_req"}, 32'(bus.req), 0);
        chk({tag, "_abort_busy"}, 32'(busy), 0);
        chk({tag, "_abort_idx"}, 32'(bus.idx), 0);
        chk({tag, "_abort_done"}, 32'(done), 0);
        chk_outs({tag, "_abort"});
        @(negedge clk);
        chk({tag, "_abort_pulse"}, 32'(abort), 0);
        chk({tag, "_abort_nodone"}, 32'(done), 0);
        return;
      end
      bus.cnt_valid = 1'b1; bus.cnt_data = dat_a[i];
      @(negedge clk);
      bus.cnt_valid = 1'b0;
      exp_cnt[i] = int'(dat_a[i]);
      exp_total += int'(dat_a[i]);
    end
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_done_req"}, 32'(bus.req), 0);
    chk({tag, "_done_busy"}, 32'(busy), 0);
    chk({tag, "_done_idx"}, 32'(bus.idx), 0);
    chk_outs({tag, "_end"});
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 0);
    chk_outs({tag, "_hold"});
  endtask

  // Watchdog: the sequence is bounded, this only guards against a stuck simulator
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_L = 1'b0; start = 1'b0; IDLE = 1'b1;
    bus.cnt_valid = 1'b0; bus.cnt_data = '0;
    model_clear();

    // 1. reset state
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(bus.req), 0);
    chk("rst_idx", 32'(bus.idx), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_abort", 32'(abort), 0);
    chk("rst_terr", 32'(timeout_err), 0);
    chk_outs("rst");
    reset_L = 1'b1;
    @(negedge clk);

    // 2. directed sweep: 2-cycle response, data = 3*idx+1
    for (int i = 0; i < 5; i++) begin lat_a[i] = 2; dat_a[i] = 5'(3 * i + 1); end
    sweep("basic", -1);
    chk("basic_total35", 32'(total), 35);

    // 3. start with IDLE low, plus stray cnt_valid while idle: nothing moves
    IDLE = 1'b0; start = 1'b1; bus.cnt_valid = 1'b1; bus.cnt_data = 5'd9;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("noidle_req", 32'(bus.req), 0);
      chk("noidle_busy", 32'(busy), 0);
    end
    IDLE = 1'b1; start = 1'b0;
    for (int c = 0; c < 2; c++) @(negedge clk);
    bus.cnt_valid = 1'b0;
    chk("stray_busy", 32'(busy), 0);
    chk_outs("noidle");

    // 4. abort while idx=2
    for (int i = 0; i < 5; i++) begin lat_a[i] = int'($urandom_range(0, 2)); dat_a[i] = 5'($urandom_range(1, 31)); end
    sweep("abort", 2);

    // Random sweeps, some aborted
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 5; i++) begin lat_a[i] = int'($urandom_range(0, 4)); dat_a[i] = 5'($urandom); end
      sweep($sformatf("rnd%0d", r), (r % 3 == 2) ? int'($urandom_range(0, 4)) : -1);
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
    end

    // 5. counter block never answers
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    model_clear();
    chk("to_req0", 32'(bus.req), 1);
`ifdef COUNTER_READER_TIMEOUT_EN
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk("to_wait_req", 32'(bus.req), 1);
      chk("to_wait_terr", 32'(timeout_err), 0);
    end
    @(negedge clk);
    chk("to_req", 32'(bus.req), 0);
    chk("to_busy", 32'(busy), 0);
    chk("to_idx", 32'(bus.idx), 0);
    chk("to_terr", 32'(timeout_err), 1);
    chk("to_done", 32'(done), 0);
    chk("to_abort", 32'(abort), 0);
    repeat (3) @(negedge clk);
    chk("to_sticky", 32'(timeout_err), 1);
    chk("to_done_later", 32'(done), 0);
`else
    repeat (20) @(negedge clk);
    chk("nto_req", 32'(bus.req), 1);
    chk("nto_busy", 32'(busy), 1);
    chk("nto_terr", 32'(timeout_err), 0);
    IDLE = 1'b0;
    @(negedge clk);
    IDLE = 1'b1;
    chk("nto_abort", 32'(abort), 1);
    chk("nto_req_off", 32'(bus.req), 0);
    @(negedge clk);
`endif
    chk_outs("to");

    // 6. maximum data, back-to-back valids: no wrap
    for (int i = 0; i < 5; i++) begin lat_a[i] = 0; dat_a[i] = 5'd31; end
    sweep("max", -1);
    chk("max_total155", 32'(total), 155);

    // 6b. async reset in the middle of a sweep
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    model_clear();
    bus.cnt_valid = 1'b1; bus.cnt_data = 5'd31;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp_cnt[i] = 31; exp_total += 31;
    end
    bus.cnt_valid = 1'b0;
    chk("mid_idx3", 32'(bus.idx), 3);
    chk_outs("mid");
    reset_L = 1'b0;
    #1;
    model_clear();
    chk("arst_req", 32'(bus.req), 0);
    chk("arst_idx", 32'(bus.idx), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_abort", 32'(abort), 0);
    chk("arst_terr", 32'(timeout_err), 0);
    chk_outs("arst");
    @(negedge clk);
    reset_L = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_req", 32'(bus.req), 0);
    chk("post_rst_busy", 32'(busy), 0);

    // A clean sweep after reset still works
    for (int i = 0; i < 5; i++) begin lat_a[i] = int'($urandom_range(0, 3)); dat_a[i] = 5'($urandom); end
    sweep("post", -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
